// File: rtl/exec_sequencer_if.sv
// Handshake and bus bundle between the execution sequencer and its fetch/stack/decoder
// neighbours.
interface exec_sequencer_if;
   logic        fetch_req;
   logic        fetch_ack;
   logic [31:0] ope_in;
   logic [31:0] ope;
   logic [31:0] eip;
   logic [1:0]  phase;
   logic        ld_strobe;
   logic        stk_req;
   logic        stk_we;
   logic        stk_ack;
   logic [31:0] ret_addr;
   logic        retired;
   logic        halt;

   modport master (
      output fetch_req, ope, eip, phase, ld_strobe, stk_req, stk_we, retired, halt,
      input  fetch_ack, ope_in, stk_ack, ret_addr
   );

   modport slave (
      input  fetch_req, ope, eip, phase, ld_strobe, stk_req, stk_we, retired, halt,
      output fetch_ack, ope_in, stk_ack, ret_addr
   );
endinterface

// File: rtl/exec_sequencer.sv
// Instruction sequencer: fetch, one or two register-load phases with an optional stack
// access in between, then eip update; halts on unknown opcodes or ack timeouts.
module exec_sequencer #(
   parameter logic [31:0] RESET_EIP   = 32'h0000_0000,
   parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
   input logic               clk2,
   input logic               reset,
   exec_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      StRst, StFetch, StExec1, StStack, StExec2, StNext, StHalt
   } state_e;

   typedef struct packed {
      logic       known;
      logic       stack;
      logic       push;
      logic [2:0] len;
   } op_info_t;

   function automatic op_info_t decode(input logic [7:0] op);
      op_info_t d;
      d = '0;
      d.known = 1'b1;
      case (op)
         8'h55:   begin d.stack = 1'b1; d.push = 1'b1; d.len = 3'd1; end
         8'h89:   d.len = 3'd2;
         8'hb8:   d.len = 3'd5;
         8'h5d:   begin d.stack = 1'b1; d.len = 3'd1; end
         8'hc3:   begin d.stack = 1'b1; d.len = 3'd1; end
         8'he8:   begin d.stack = 1'b1; d.push = 1'b1; d.len = 3'd5; end
         default: d.known = 1'b0;
      endcase
      return d;
   endfunction

   state_e      state_q;
   logic [31:0] eip_q;
   logic [31:0] ope_q;
   logic [31:0] ret_q;
   logic [7:0]  wait_cnt_q;
   logic [1:0]  phase_q;
   logic        ld_strobe_q;
   logic        fetch_req_q;
   logic        stk_req_q;
   logic        stk_we_q;
   logic        retired_q;
   logic        halt_q;

   op_info_t    cur_info;
   op_info_t    in_info;
   logic [31:0] rel;
   logic [31:0] next_eip;

   always_comb begin
      cur_info = decode(ope_q[31:24]);
      in_info  = decode(bus.ope_in[31:24]);
      rel      = {{8{ope_q[23]}}, ope_q[23:0]};
      case (ope_q[31:24])
         8'he8:   next_eip = eip_q + 32'd5 + rel;
         8'hc3:   next_eip = ret_q;
         default: next_eip = eip_q + {29'd0, cur_info.len};
      endcase
   end

   // Outputs are registered: each transition sets the values seen in the state it enters.
   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         state_q     <= StRst;
         eip_q       <= RESET_EIP;
         ope_q       <= '0;
         ret_q       <= '0;
         wait_cnt_q  <= '0;
         phase_q     <= 2'd0;
         ld_strobe_q <= 1'b0;
         fetch_req_q <= 1'b0;
         stk_req_q   <= 1'b0;
         stk_we_q    <= 1'b0;
         retired_q   <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         retired_q <= 1'b0;
         case (state_q)
            StRst: begin
               fetch_req_q <= 1'b1;
               wait_cnt_q  <= '0;
               state_q     <= StFetch;
            end
            StFetch: begin
               if (bus.fetch_ack) begin
                  ope_q       <= bus.ope_in;
                  fetch_req_q <= 1'b0;
                  phase_q     <= in_info.known ? 2'd1 : 2'd0;
                  ld_strobe_q <= in_info.known;
                  state_q     <= StExec1;
               end else if (wait_cnt_q == ACK_TIMEOUT) begin
                  fetch_req_q <= 1'b0;
                  halt_q      <= 1'b1;
                  state_q     <= StHalt;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StExec1: begin
               phase_q     <= 2'd0;
               ld_strobe_q <= 1'b0;
               if (!cur_info.known) begin
                  halt_q  <= 1'b1;
                  state_q <= StHalt;
               end else if (cur_info.stack) begin
                  stk_req_q  <= 1'b1;
                  stk_we_q   <= cur_info.push;
                  wait_cnt_q <= '0;
                  state_q    <= StStack;
               end else begin
                  eip_q     <= next_eip;
                  retired_q <= 1'b1;
                  state_q   <= StNext;
               end
            end
            StStack: begin
               if (bus.stk_ack) begin
                  if (ope_q[31:24] == 8'hc3) ret_q <= bus.ret_addr;
                  stk_req_q   <= 1'b0;
                  stk_we_q    <= 1'b0;
                  phase_q     <= 2'd2;
                  ld_strobe_q <= 1'b1;
                  state_q     <= StExec2;
               end else if (wait_cnt_q == ACK_TIMEOUT) begin
                  stk_req_q <= 1'b0;
                  stk_we_q  <= 1'b0;
                  halt_q    <= 1'b1;
                  state_q   <= StHalt;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StExec2: begin
               phase_q     <= 2'd0;
               ld_strobe_q <= 1'b0;
               eip_q       <= next_eip;
               retired_q   <= 1'b1;
               state_q     <= StNext;
            end
            StNext: begin
               fetch_req_q <= 1'b1;
               wait_cnt_q  <= '0;
               state_q     <= StFetch;
            end
            StHalt: state_q <= StHalt;
            default: begin
               halt_q  <= 1'b1;
               state_q <= StHalt;
            end
         endcase
      end
   end

   assign bus.fetch_req = fetch_req_q;
   assign bus.ope       = ope_q;
   assign bus.eip       = eip_q;
   assign bus.phase     = phase_q;
   assign bus.ld_strobe = ld_strobe_q;
   assign bus.stk_req   = stk_req_q;
   assign bus.stk_we    = stk_we_q;
   assign bus.retired   = retired_q;
   assign bus.halt      = halt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus pushes expected events, a negedge monitor
// pops and compares them as the sequencer produces strobes, stack requests, retires and halts.
module tb_exec_sequencer;

   localparam int EvStb  = 0;
   localparam int EvStk  = 1;
   localparam int EvRet  = 2;
   localparam int EvHalt = 3;

   typedef struct {
      int          kind;
      logic [31:0] val;
   } evt_t;

   logic clk2;
   logic reset;
   exec_sequencer_if bus ();

   exec_sequencer #(
      .RESET_EIP   (32'h0000_0000),
      .ACK_TIMEOUT (8'd255)
   ) dut (
      .clk2  (clk2),
      .reset (reset),
      .bus   (bus)
   );

   evt_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic prev_stk = 1'b0;
   logic prev_halt = 1'b0;

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] val);
      evt_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [31:0] val);
      evt_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d value %h, expected none", kind, val);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event_kind(exp %0d)", e.kind), kind, e.kind);
         check($sformatf("event_value(kind %0d)", e.kind), val, e.val);
      end
   endtask

   // Monitor
   always @(negedge clk2) begin
      if (!reset) begin
         if (bus.ld_strobe) observe(EvStb, {30'd0, bus.phase});
         if (bus.stk_req && !prev_stk) observe(EvStk, {31'd0, bus.stk_we});
         if (bus.retired) observe(EvRet, bus.eip);
         if (bus.halt && !prev_halt) observe(EvHalt, bus.eip);
      end
      prev_stk  = bus.stk_req;
      prev_halt = bus.halt;
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_eip"}, bus.eip, 32'h0);
      check({tag, "_ope"}, bus.ope, 32'h0);
      check({tag, "_phase"}, {30'd0, bus.phase}, 32'd0);
      check({tag, "_outs"}, {27'd0, bus.ld_strobe, bus.fetch_req, bus.stk_req, bus.retired,
                             bus.halt}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk2);
      #2 reset = 1'b1;
      #1 check_reset_values(tag);
      repeat (2) @(negedge clk2);
      reset = 1'b0;
   endtask

   // sel 0: fetch_req, sel 1: stk_req; returns on the negedge where the request is seen.
   task automatic wait_req(input int sel, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk2);
         if ((sel == 0) ? bus.fetch_req : bus.stk_req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check($sformatf("req%0d_timeout", sel), 32'd0, 32'd1);
   endtask

   task automatic serve_fetch(input logic [31:0] word, input int waits);
      bit ok;
      wait_req(0, ok);
      if (ok) begin
         repeat (waits) @(negedge clk2);
         bus.ope_in    = word;
         bus.fetch_ack = 1'b1;
         @(negedge clk2);
         bus.fetch_ack = 1'b0;
         bus.ope_in    = 32'hdead_beef;
      end
   endtask

   task automatic serve_stack(input logic [31:0] ret, input int waits);
      bit ok;
      wait_req(1, ok);
      if (ok) begin
         repeat (waits) @(negedge clk2);
         bus.ret_addr = ret;
         bus.stk_ack  = 1'b1;
         @(negedge clk2);
         bus.stk_ack  = 1'b0;
         bus.ret_addr = 32'hbad0_bad0;
      end
   endtask

   // Full stack-type instruction: strobe 1, stack access, strobe 2, retire at new_eip.
   task automatic run_stack_op(input logic [31:0] word, input logic we, input logic [31:0] ret,
                               input int waits, input logic [31:0] new_eip);
      push(EvStb, 32'd1);
      push(EvStk, {31'd0, we});
      push(EvStb, 32'd2);
      push(EvRet, new_eip);
      serve_fetch(word, 0);
      serve_stack(ret, waits);
   endtask

   task automatic run_simple_op(input logic [31:0] word, input int waits,
                                input logic [31:0] new_eip);
      push(EvStb, 32'd1);
      push(EvRet, new_eip);
      serve_fetch(word, waits);
   endtask

   initial begin
      bit ok;
      reset         = 1'b0;
      bus.fetch_ack = 1'b0;
      bus.stk_ack   = 1'b0;
      bus.ope_in    = 32'h0;
      bus.ret_addr  = 32'h0;

      do_reset("rst0");
      run_simple_op(32'hb800_0005, 2, 32'h0000_0005);
      run_stack_op(32'h5512_3456, 1'b1, 32'h0, 3, 32'h0000_0006);
      run_stack_op(32'hc300_0000, 1'b0, 32'h0000_0100, 1, 32'h0000_0100);
      run_stack_op(32'he8ff_fff0, 1'b1, 32'h0, 0, 32'h0000_00f5);
      run_stack_op(32'hc3ab_cdef, 1'b0, 32'h0000_1234, 2, 32'h0000_1234);
      run_simple_op(32'h8900_0000, 0, 32'h0000_1236);
      run_stack_op(32'h5d00_0000, 1'b0, 32'h0, 0, 32'h0000_1237);
      run_stack_op(32'hc300_0000, 1'b0, 32'hffff_ffff, 0, 32'hffff_ffff);
      run_simple_op(32'h8900_0000, 0, 32'h0000_0001);
      // Ack in the cycle the wait count reaches the limit must still be taken.
      run_simple_op(32'h8900_0000, 255, 32'h0000_0003);

      // Unknown opcode halts with eip untouched; later acks do nothing.
      push(EvHalt, 32'h0000_0003);
      serve_fetch(32'h0012_3456, 0);
      repeat (3) @(negedge clk2);
      check("halt_sticky", {31'd0, bus.halt}, 32'd1);
      bus.fetch_ack = 1'b1;
      bus.stk_ack   = 1'b1;
      bus.ope_in    = 32'hb800_0005;
      repeat (3) @(negedge clk2);
      bus.fetch_ack = 1'b0;
      bus.stk_ack   = 1'b0;
      check("halt_eip", bus.eip, 32'h0000_0003);
      check("halt_reqs", {30'd0, bus.fetch_req, bus.stk_req}, 32'd0);
      check("halt_still", {31'd0, bus.halt}, 32'd1);

      // One cycle past the limit is too late.
      do_reset("rst1");
      push(EvHalt, 32'h0);
      serve_fetch(32'h8900_0000, 256);
      repeat (2) @(negedge clk2);
      check("timeout_halt", {31'd0, bus.halt}, 32'd1);

      // Reset while waiting on the stack abandons the instruction.
      do_reset("rst2");
      push(EvStb, 32'd1);
      push(EvStk, 32'd1);
      serve_fetch(32'h5500_0000, 0);
      wait_req(1, ok);
      repeat (2) @(negedge clk2);
      do_reset("rst_stack");
      repeat (5) @(negedge clk2);
      check("post_reset_eip", bus.eip, 32'h0);
      check("post_reset_fetch", {31'd0, bus.fetch_req}, 32'd1);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
